// File: rtl/dogx_mode_sequencer.sv
// Purpose: glitch-free DOGX mode/threshold change (mute, clear noise shaper, settle, unmute); optional DOGX_SEQ_SKIP_SAME_EN skips no-op requests.
// Latency: accept-to-done = cycles to first enable_3M + (SETTLE_FRAMES+2) frames; 1 cycle for reject or skip.
// Backpressure: req_ready is high only in IDLE; req_valid outside IDLE is ignored, never queued.
module dogx_mode_sequencer #(
  parameter int unsigned SETTLE_FRAMES = 16,
  parameter logic [8:0]  DEF_TH_HIGH   = 9'd200,
  parameter logic [8:0]  DEF_TH_LOW    = 9'd100,
  parameter logic [4:0]  DEF_MASK      = 5'd0
) (
  input  logic       CLK_24M,
  input  logic       reset,
  input  logic       enable_3M,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [8:0] req_th_high,
  input  logic [8:0] req_th_low,
  input  logic [4:0] req_timeout_mask,
  output logic       operation_mode,
  output logic [8:0] alpha_th_high,
  output logic [8:0] alpha_th_low,
  output logic [4:0] alpha_timeout_mask,
  output logic       ns_clear,
  output logic       output_mute,
  output logic       busy,
  output logic       done,
  output logic       req_err
);

  typedef enum logic [2:0] {IDLE, ALIGN, MUTE, SETTLE, UNMUTE} state_t;

  localparam logic [7:0] LAST_FRAME = 8'(SETTLE_FRAMES - 1);

  state_t     state_q, state_nxt;
  logic [7:0] frame_cnt, frame_cnt_nxt;

  logic       sh_mode, sh_mode_nxt;
  logic [8:0] sh_th_high, sh_th_high_nxt;
  logic [8:0] sh_th_low, sh_th_low_nxt;
  logic [4:0] sh_mask, sh_mask_nxt;

  logic       mode_nxt;
  logic [8:0] th_high_nxt, th_low_nxt;
  logic [4:0] mask_nxt;
  logic       ns_clear_nxt, output_mute_nxt, done_nxt, req_err_nxt;
  logic       req_ready_nxt, busy_nxt;

  logic accept, th_bad, same_cfg;

  assign accept = req_valid && req_ready;
  assign th_bad = req_th_low > req_th_high;

`ifdef DOGX_SEQ_SKIP_SAME_EN
  assign same_cfg = (req_mode == operation_mode) && (req_th_high == alpha_th_high) &&
                    (req_th_low == alpha_th_low) && (req_timeout_mask == alpha_timeout_mask);
`else
  assign same_cfg = 1'b0;
`endif

  // State and every output are registered here; the two comb blocks below compute next values.
  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      state_q            <= IDLE;
      frame_cnt          <= 8'd0;
      sh_mode            <= 1'b0;
      sh_th_high         <= DEF_TH_HIGH;
      sh_th_low          <= DEF_TH_LOW;
      sh_mask            <= DEF_MASK;
      operation_mode     <= 1'b0;
      alpha_th_high      <= DEF_TH_HIGH;
      alpha_th_low       <= DEF_TH_LOW;
      alpha_timeout_mask <= DEF_MASK;
      ns_clear           <= 1'b0;
      output_mute        <= 1'b0;
      done               <= 1'b0;
      req_err            <= 1'b0;
      req_ready          <= 1'b1;
      busy               <= 1'b0;
    end else begin
      state_q            <= state_nxt;
      frame_cnt          <= frame_cnt_nxt;
      sh_mode            <= sh_mode_nxt;
      sh_th_high         <= sh_th_high_nxt;
      sh_th_low          <= sh_th_low_nxt;
      sh_mask            <= sh_mask_nxt;
      operation_mode     <= mode_nxt;
      alpha_th_high      <= th_high_nxt;
      alpha_th_low       <= th_low_nxt;
      alpha_timeout_mask <= mask_nxt;
      ns_clear           <= ns_clear_nxt;
      output_mute        <= output_mute_nxt;
      done               <= done_nxt;
      req_err            <= req_err_nxt;
      req_ready          <= req_ready_nxt;
      busy               <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept && !th_bad && !same_cfg) state_nxt = ALIGN;
      ALIGN:   if (enable_3M) state_nxt = MUTE;
      MUTE:    if (enable_3M) state_nxt = SETTLE;
      SETTLE:  if (enable_3M && (frame_cnt == LAST_FRAME)) state_nxt = UNMUTE;
      UNMUTE:  if (enable_3M) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_cnt_nxt   = frame_cnt;
    sh_mode_nxt     = sh_mode;
    sh_th_high_nxt  = sh_th_high;
    sh_th_low_nxt   = sh_th_low;
    sh_mask_nxt     = sh_mask;
    mode_nxt        = operation_mode;
    th_high_nxt     = alpha_th_high;
    th_low_nxt      = alpha_th_low;
    mask_nxt        = alpha_timeout_mask;
    ns_clear_nxt    = ns_clear;
    output_mute_nxt = output_mute;
    done_nxt        = 1'b0;
    req_err_nxt     = 1'b0;

    if (accept) begin
      sh_mode_nxt    = req_mode;
      sh_th_high_nxt = req_th_high;
      sh_th_low_nxt  = req_th_low;
      sh_mask_nxt    = req_timeout_mask;
    end

    case (state_q)
      IDLE: begin
        if (accept && th_bad) req_err_nxt = 1'b1;
        else if (accept && same_cfg) done_nxt = 1'b1;
      end
      ALIGN: begin
        if (enable_3M) output_mute_nxt = 1'b1;
      end
      // Config switches only while muted, together with the noise-shaper clear.
      MUTE: begin
        if (enable_3M) begin
          mode_nxt      = sh_mode;
          th_high_nxt   = sh_th_high;
          th_low_nxt    = sh_th_low;
          mask_nxt      = sh_mask;
          ns_clear_nxt  = 1'b1;
          frame_cnt_nxt = 8'd0;
        end
      end
      SETTLE: begin
        if (enable_3M) begin
          frame_cnt_nxt = frame_cnt + 8'd1;
          if (frame_cnt == LAST_FRAME) ns_clear_nxt = 1'b0;
        end
      end
      UNMUTE: begin
        if (enable_3M) begin
          output_mute_nxt = 1'b0;
          done_nxt        = 1'b1;
        end
      end
      default: begin
        output_mute_nxt = 1'b0;
        ns_clear_nxt    = 1'b0;
      end
    endcase

    req_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_dogx_mode_sequencer.sv
// Directed bench for dogx_mode_sequencer: scoreboard of expected done/req_err pulses plus timed mute/clear probes.
// Strobe enable_3M is high for the posedge following every 8th negedge.
module tb_dogx_mode_sequencer;
  localparam int SF = 16;

  logic       CLK_24M = 1'b0;
  logic       reset = 1'b1;
  logic       enable_3M = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_mode = 1'b0;
  logic [8:0] req_th_high = 9'd0;
  logic [8:0] req_th_low = 9'd0;
  logic [4:0] req_timeout_mask = 5'd0;
  logic       operation_mode;
  logic [8:0] alpha_th_high, alpha_th_low;
  logic [4:0] alpha_timeout_mask;
  logic       ns_clear, output_mute, busy, done, req_err;

  always #20 CLK_24M = ~CLK_24M;

  dogx_mode_sequencer #(.SETTLE_FRAMES(SF)) dut (
    .CLK_24M(CLK_24M), .reset(reset), .enable_3M(enable_3M),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_th_high(req_th_high), .req_th_low(req_th_low),
    .req_timeout_mask(req_timeout_mask),
    .operation_mode(operation_mode), .alpha_th_high(alpha_th_high),
    .alpha_th_low(alpha_th_low), .alpha_timeout_mask(alpha_timeout_mask),
    .ns_clear(ns_clear), .output_mute(output_mute), .busy(busy),
    .done(done), .req_err(req_err)
  );

  typedef struct {
    logic       err;
    logic       mode;
    logic [8:0] hi;
    logic [8:0] lo;
    logic [4:0] mask;
    int         due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic       m_mode;
  logic [8:0] m_hi, m_lo;
  logic [4:0] m_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic mo, input logic [8:0] hi, input logic [8:0] lo, input logic [4:0] mk);
    chk({tag, "_mode"}, operation_mode, mo);
    chk({tag, "_hi"}, alpha_th_high, hi);
    chk({tag, "_lo"}, alpha_th_low, lo);
    chk({tag, "_mask"}, alpha_timeout_mask, mk);
  endtask

  // Advance to the next negedge, score any pulse, then set the strobe for the coming posedge.
  task automatic tick();
    exp_t e;
    @(negedge CLK_24M);
    cyc++;
    if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("sb_overdue", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (done || req_err) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", {30'd0, done, req_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_cycle", cyc, e.due);
        chk("sb_req_err", req_err, e.err);
        chk("sb_done", done, !e.err);
        chk_cfg("sb_cfg", e.mode, e.hi, e.lo, e.mask);
      end
    end
    enable_3M = (cyc % 8 == 0);
  endtask

  task automatic step_to(input int c);
    while (cyc < c) tick();
  endtask

  function automatic int first_strobe(input int n);
    return n + 8 - (n % 8);
  endfunction

  task automatic model_defaults();
    m_mode = 1'b0;
    m_hi   = 9'd200;
    m_lo   = 9'd100;
    m_mask = 5'd0;
  endtask

  // Drive one request at the current negedge; returns the accept cycle and the expected pulse cycle.
  task automatic request(input logic mo, input logic [8:0] hi, input logic [8:0] lo, input logic [4:0] mk,
                         output int n, output int due);
    exp_t e;
    logic same;
    n = cyc;
    chk("ready_before_req", req_ready, 1'b1);
    same = 1'b0;
`ifdef DOGX_SEQ_SKIP_SAME_EN
    same = (mo == m_mode) && (hi == m_hi) && (lo == m_lo) && (mk == m_mask);
`endif
    e.err = (lo > hi);
    if (e.err || same) due = n + 1;
    else due = first_strobe(n) + 8 * (SF + 2) + 1;
    if (!e.err) begin
      m_mode = mo; m_hi = hi; m_lo = lo; m_mask = mk;
    end
    e.mode = m_mode; e.hi = m_hi; e.lo = m_lo; e.mask = m_mask; e.due = due;
    sb.push_back(e);
    req_valid = 1'b1;
    req_mode = mo; req_th_high = hi; req_th_low = lo; req_timeout_mask = mk;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, due, m;
    model_defaults();

    // Reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ns_clear", ns_clear, 1'b0);
    chk("rst_mute", output_mute, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", req_err, 1'b0);
    chk_cfg("rst_cfg", 1'b0, 9'd200, 9'd100, 5'd0);
    reset = 1'b0;
    tick();

    // Illegal thresholds are rejected with a single req_err
    request(1'b1, 9'd110, 9'd120, 5'd4, n, due);
    chk("err_ready", req_ready, 1'b1);
    chk("err_busy", busy, 1'b0);
    chk_cfg("err_cfg", 1'b0, 9'd200, 9'd100, 5'd0);
    tick(); tick();
    chk("err_no_second", req_err, 1'b0);

    // Full sequence, accept one cycle after a strobe
    while (cyc % 8 != 1) tick();
    request(1'b1, 9'd300, 9'd50, 5'd3, n, due);
    m = first_strobe(n);
    chk("seq_latency", due - n - 1, 151);
    chk("seq_ready", req_ready, 1'b0);
    chk("seq_busy", busy, 1'b1);
    step_to(m);
    chk("seq_mute_pre", output_mute, 1'b0);
    step_to(m + 1);
    chk("seq_mute_rise", output_mute, 1'b1);
    chk("seq_ns_pre", ns_clear, 1'b0);
    chk_cfg("seq_cfg_old", 1'b0, 9'd200, 9'd100, 5'd0);
    step_to(m + 8);
    chk("seq_ns_still0", ns_clear, 1'b0);
    step_to(m + 9);
    chk("seq_ns_rise", ns_clear, 1'b1);
    chk_cfg("seq_cfg_new", 1'b1, 9'd300, 9'd50, 5'd3);
    step_to(m + 8 * 17);
    chk("seq_ns_hold", ns_clear, 1'b1);
    step_to(m + 8 * 17 + 1);
    chk("seq_ns_fall", ns_clear, 1'b0);
    chk("seq_mute_hold", output_mute, 1'b1);
    step_to(due);
    chk("seq_mute_fall", output_mute, 1'b0);
    chk("seq_ready_end", req_ready, 1'b1);
    chk("seq_busy_end", busy, 1'b0);
    tick();

    // Equal thresholds are legal; req_valid during SETTLE is ignored
    request(1'b0, 9'd150, 9'd150, 5'd7, n, due);
    step_to(n + 40);
    req_valid = 1'b1;
    req_mode = 1'b1; req_th_high = 9'd400; req_th_low = 9'd10; req_timeout_mask = 5'd31;
    step_to(n + 100);
    chk("ign_ready", req_ready, 1'b0);
    chk_cfg("ign_mid_cfg", 1'b0, 9'd150, 9'd150, 5'd7);
    req_valid = 1'b0;
    step_to(due + 2);
    chk_cfg("ign_end_cfg", 1'b0, 9'd150, 9'd150, 5'd7);
    chk("ign_idle", req_ready, 1'b1);

    // Reset in the middle of SETTLE aborts without done
    request(1'b1, 9'd257, 9'd3, 5'd9, n, due);
    step_to(n + 60);
    chk("abort_ns_before", ns_clear, 1'b1);
    reset = 1'b1;
    sb.delete();
    model_defaults();
    tick();
    reset = 1'b0;
    chk("abort_ns", ns_clear, 1'b0);
    chk("abort_mute", output_mute, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    chk_cfg("abort_cfg", 1'b0, 9'd200, 9'd100, 5'd0);
    step_to(cyc + 200);

    // Request identical to the current (default) config
    request(1'b0, 9'd200, 9'd100, 5'd0, n, due);
`ifdef DOGX_SEQ_SKIP_SAME_EN
    for (int i = 0; i < 24; i++) begin
      chk("skip_no_mute", output_mute, 1'b0);
      tick();
    end
    chk("skip_ready", req_ready, 1'b1);
`else
    chk("same_busy", busy, 1'b1);
    step_to(first_strobe(n) + 1);
    chk("same_mute", output_mute, 1'b1);
    step_to(due + 1);
`endif
    chk_cfg("same_cfg", 1'b0, 9'd200, 9'd100, 5'd0);

    // Accept coincident with a strobe: that strobe does not count
    while (cyc % 8 != 0) tick();
    request(1'b1, 9'd511, 9'd0, 5'd16, n, due);
    step_to(n + 8);
    chk("coin_mute_pre", output_mute, 1'b0);
    step_to(n + 9);
    chk("coin_mute_rise", output_mute, 1'b1);
    step_to(due + 2);
    chk_cfg("coin_cfg", 1'b1, 9'd511, 9'd0, 5'd16);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
